// File: rtl/rf_operand_fetch.sv
// Operand-fetch front end for a 32x32 register file: registered, backpressurable response with
// write-first bypass. Optional feature macro: ZERO_REG_EN (address 0 hardwired to zero).
module rf_operand_fetch #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rs1,
  input  logic [AW-1:0] req_rs2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data1,
  output logic [DW-1:0] rsp_data2,
  output logic [CW-1:0] bypass_cnt,
  output logic [AW-1:0] ReadAddress1,
  output logic [AW-1:0] ReadAddress2,
  output logic [AW-1:0] WriteAddress,
  output logic [DW-1:0] WriteData,
  output logic          ReadWriteEn,
  input  logic [DW-1:0] ReadData1,
  input  logic [DW-1:0] ReadData2
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data1_q, data2_q;
  logic [DW-1:0] data1_d, data2_d;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_sum;
  logic [1:0]    inc;
  logic          accept;
  logic          zero1, zero2, wb_ok;
  logic          byp1, byp2;

`ifdef ZERO_REG_EN
  assign zero1 = (req_rs1 == '0);
  assign zero2 = (req_rs2 == '0);
  assign wb_ok = (wb_addr != '0);
`else
  assign zero1 = 1'b0;
  assign zero2 = 1'b0;
  assign wb_ok = 1'b1;
`endif

  assign ReadAddress1 = req_rs1;
  assign ReadAddress2 = req_rs2;
  assign WriteAddress = wb_addr;
  assign WriteData    = wb_data;
  assign ReadWriteEn  = wb_valid && wb_ok && !rst;

  assign rsp_valid  = (state_q == StFull);
  assign req_ready  = !rsp_valid || rsp_ready;
  assign accept     = req_valid && req_ready;
  assign rsp_data1  = data1_q;
  assign rsp_data2  = data2_q;
  assign bypass_cnt = cnt_q;

  // Write-first: a same-cycle writeback wins over the stale RF read.
  assign byp1 = wb_valid && (wb_addr == req_rs1) && !zero1;
  assign byp2 = wb_valid && (wb_addr == req_rs2) && !zero2;
  assign inc  = {1'b0, byp1} + {1'b0, byp2};
  assign cnt_sum = {1'b0, cnt_q} + (CW+1)'(inc);

  always_comb begin
    state_d = state_q;
    data1_d = data1_q;
    data2_d = data2_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (rsp_ready && !accept) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (accept) begin
      data1_d = zero1 ? '0 : (byp1 ? wb_data : ReadData1);
      data2_d = zero2 ? '0 : (byp2 ? wb_data : ReadData2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data1_q <= '0;
      data2_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      if (accept) cnt_q <= cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    end
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Scoreboard bench for rf_operand_fetch: behavioural RF plus reference model of the fetch rules.
module tb_rf_operand_fetch;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_rs1, req_rs2;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic [CW-1:0] bypass_cnt;
  logic [AW-1:0] ReadAddress1, ReadAddress2, WriteAddress;
  logic [DW-1:0] WriteData, ReadData1, ReadData2;
  logic          ReadWriteEn;

  rf_operand_fetch #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1),
    .rsp_data2(rsp_data2), .bypass_cnt(bypass_cnt), .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .ReadWriteEn(ReadWriteEn), .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  // Register file the block drives.
  logic [DW-1:0] rf [2**AW];
  assign ReadData1 = rf[ReadAddress1];
  assign ReadData2 = rf[ReadAddress2];
  always @(posedge clk) if (ReadWriteEn) rf[WriteAddress] <= WriteData;

  // Reference model state.
  typedef struct {logic [DW-1:0] d1; logic [DW-1:0] d2; int cnt;} exp_t;
  exp_t          sb[$];
  logic [DW-1:0] ref_regs [2**AW];
  logic          m_full;
  int            m_cnt;
  int            errors = 0;
  int            checks = 0;
`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] a, output bit byp);
    byp = 1'b0;
    if (ZeroReg && a == 0) return '0;
    if (wb_valid && wb_addr == a) begin
      byp = 1'b1;
      return wb_data;
    end
    return ref_regs[a];
  endfunction

  // Called right at the active edge with the inputs that were driven during the cycle.
  task automatic model_step();
    bit   b1, b2;
    bit   acc;
    exp_t e;
    if (rst) begin
      m_full = 1'b0;
      m_cnt  = 0;
      sb.delete();
      return;
    end
    acc = req_valid && (!m_full || rsp_ready);
    if (acc) begin
      e.d1  = operand(req_rs1, b1);
      e.d2  = operand(req_rs2, b2);
      m_cnt = m_cnt + int'(b1) + int'(b2);
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
      e.cnt = m_cnt;
      sb.push_back(e);
    end
    m_full = acc || (m_full && !rsp_ready);
    if (wb_valid && !(ZeroReg && wb_addr == 0)) ref_regs[wb_addr] = wb_data;
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rr);
    req_valid = v; req_rs1 = a1; req_rs2 = a2;
    wb_valid = wv; wb_addr = wa; wb_data = wd; rsp_ready = rr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compares the presented response against the scoreboard head on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        chk("req_ready", 64'(req_ready), 64'(!m_full || rsp_ready));
        chk("ReadWriteEn", 64'(ReadWriteEn),
            64'(wb_valid && !(ZeroReg && wb_addr == 0)));
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            chk("rsp_data1", 64'(rsp_data1), 64'(sb[0].d1));
            chk("rsp_data2", 64'(rsp_data2), 64'(sb[0].d2));
            chk("bypass_cnt", 64'(bypass_cnt), 64'(sb[0].cnt));
            if (rsp_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      rf[i] = '0;
      ref_regs[i] = '0;
    end
    m_full = 1'b0; m_cnt = 0;
    rst = 1'b1;
    req_valid = 0; req_rs1 = 0; req_rs2 = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; rsp_ready = 1;
    @(posedge clk); model_step();
    @(posedge clk); model_step();
    #1 rst = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_bypass_cnt", 64'(bypass_cnt), 64'd0);
    chk("reset_rsp_data1", 64'(rsp_data1), 64'd0);
    #1;

    // Writes then plain fetch.
    cycle(0, 0, 0, 1, 8, 294, 1);
    cycle(0, 0, 0, 1, 13, 194, 1);
    cycle(0, 0, 0, 1, 10, 123, 1);
    cycle(1, 8, 13, 0, 0, 0, 1);
    // Same-cycle bypass of rs1, then RF read of the written value.
    cycle(1, 3, 10, 1, 3, 48, 1);
    cycle(1, 3, 3, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Hold with backpressure; a later write must not disturb the snapshot.
    cycle(1, 8, 8, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 8, 13, 1, 8, 7, 0);
    cycle(1, 8, 8, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back throughput.
    for (int i = 0; i < 4; i++) cycle(1, AW'(i + 8), AW'(13 - i), 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset during a held response.
    cycle(1, 8, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    wb_valid = 1; wb_addr = 9; wb_data = 32'hdead; rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_data1", 64'(rsp_data1), 64'd0);
    chk("async_rst_data2", 64'(rsp_data2), 64'd0);
    chk("async_rst_cnt", 64'(bypass_cnt), 64'd0);
    chk("async_rst_wen", 64'(ReadWriteEn), 64'd0);
    @(posedge clk); model_step();
    #1 rst = 1'b0; wb_valid = 0;
    #1;

    // Address 0 write and double read in the same cycle.
    cycle(1, 0, 0, 1, 0, 55, 1);
    cycle(1, 0, 8, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic on a narrow address range to provoke bypasses and saturation.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), $urandom,
            1'($urandom_range(0, 3) != 0));
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Initiator-side driver for the 32x32 register file: owns its ReadAddress1/ReadAddress2/WriteAddress/WriteData/ReadWriteEn inputs and consumes its ReadData1/ReadData2 outputs.
- Accepts operand-fetch requests on a valid/ready channel and writeback writes on a fire-and-forget channel.
- Returns both operands in a registered, backpressurable response stage, with write-to-read bypass.
- Sits between decode/issue and the register file.

Parameters:
- AW, 5, register address width (2**AW registers)
- DW, 32, data width
- CW, 16, width of bypass event counter

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when req_valid && req_ready at posedge
- req_rs1  in  AW  first operand address
- req_rs2  in  AW  second operand address
- wb_valid  in  1  writeback request; always accepted, no backpressure
- wb_addr  in  AW  writeback address
- wb_data  in  DW  writeback data
- rsp_valid  out  1  operand response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data1  out  DW  operand 1
- rsp_data2  out  DW  operand 2
- bypass_cnt  out  CW  saturating count of bypassed operands
- ReadAddress1  out  AW  to register file
- ReadAddress2  out  AW  to register file
- WriteAddress  out  AW  to register file
- WriteData  out  DW  to register file
- ReadWriteEn  out  1  register file write enable
- ReadData1  in  DW  from register file (combinational read)
- ReadData2  in  DW  from register file (combinational read)

Behaviour:
- Register file contract: reads are combinational; a write with ReadWriteEn=1 takes effect at the posedge.
- Reset (async, rst=1):
  - rsp_valid=0, rsp_data1/2=0, bypass_cnt=0, state=EMPTY.
  - ReadWriteEn is forced 0 combinationally while rst=1.
- RF drive:
  - ReadAddress1=req_rs1 and ReadAddress2=req_rs2, unregistered.
  - WriteAddress=wb_addr, WriteData=wb_data, ReadWriteEn=wb_valid && !rst.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single-entry stage; full throughput when the consumer is always ready).
  - Accept at edge N gives rsp_valid=1 after edge N: 1-cycle latency.
- FSM:
  - EMPTY: accept -> FULL.
  - FULL: if rsp_ready && accept -> FULL with new data.
  - FULL: if rsp_ready && !accept -> EMPTY.
  - FULL: if !rsp_ready -> hold; rsp_data1/2 stable.
- Bypass (write-first):
  - On accept, if wb_valid && wb_addr==req_rs1, capture wb_data into rsp_data1 instead of ReadData1; same rule for rs2.
  - rs1==rs2==wb_addr bypasses both.
- Snapshot semantics: a held response is NOT updated by later writebacks to the same address.
- bypass_cnt:
  - Increments by number of operands bypassed on an accept (0, 1 or 2).
  - Saturates at all-ones; never wraps.
- Simultaneous writeback and accept to unrelated addresses: both proceed in the same cycle.
- Reset mid-hold drops the pending response; rsp_valid=0 immediately (async).

Optional Feature:
- ZERO_REG_EN defined:
  - Address 0 reads as 0: rsp_data is 0 for rs==0, regardless of ReadData or bypass.
  - wb_valid with wb_addr==0 drives ReadWriteEn=0.
  - Bypass to address 0 is not counted.
- ZERO_REG_EN undefined: address 0 is an ordinary register.

Test Plan:
- Reset then write 294 to r8 and 194 to r13 on consecutive cycles; request rs1=8, rs2=13 -> one cycle later rsp_valid=1, rsp_data1=294, rsp_data2=194, bypass_cnt=0.
- Same-cycle wb_addr=3, wb_data=48 and request rs1=3, rs2=10 (r10 holds 123) -> rsp_data1=48, rsp_data2=123, bypass_cnt=1; the next read of r3 returns 48 from the RF.
- Hold rsp_ready=0 for 3 cycles with response r8=294 held, then write r8=7 -> rsp_data1 stays 294, req_ready=0; when rsp_ready=1, the next request for r8 returns 7.
- Back-to-back requests with rsp_ready=1 for 4 cycles -> 4 responses on consecutive cycles, req_ready continuously 1.
- Assert rst while rsp_valid=1 -> rsp_valid, rsp_data1/2 and bypass_cnt drop to 0 before the next edge; ReadWriteEn=0 even with wb_valid=1.
- With ZERO_REG_EN, write 55 to r0 and request rs1=rs2=0 in the same cycle -> ReadWriteEn=0, rsp_data1=rsp_data2=0, bypass_cnt unchanged; without it, both are 55 and bypass_cnt +2.
